tank_mover: RTL and testbench

TANK_MOVER -- requirements
Module: tank_mover

---
 rtl/tank_mover.sv | 196 +++++++++++++++++++
 tb/tb_tank_mover.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/tank_mover.sv
//------------------------------------------------------------------------------
// Module  : tank_mover
// Brief   : Tile-based tank movement: requests a move from the arbiter, then
//           steps pixel by pixel to the adjacent tile. Optional macro
//           TANK_MOVER_AUTOREPEAT_EN keeps moving while the key is held.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tank_mover #(
  parameter int TILE_PX  = 9,
  parameter int INIT_TX  = 0,
  parameter int INIT_TY  = 12,
  parameter int MAX_TILE = 12
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] key_dir,
  input  logic       tick,
  input  logic [2:0] grant,
  output logic [2:0] tdirection,
  output logic       tmoving,
  output logic [3:0] tx1,
  output logic [3:0] ty1,
  output logic [3:0] tx2,
  output logic [3:0] ty2,
  output logic [7:0] px,
  output logic [6:0] py,
  output logic [1:0] facing
);

  localparam logic [1:0] c_IDLE   = 2'd0;
  localparam logic [1:0] c_REQ    = 2'd1;
  localparam logic [1:0] c_MOVE   = 2'd2;
  localparam logic [1:0] c_SETTLE = 2'd3;

  localparam int c_STEP_W = (TILE_PX > 2) ? $clog2(TILE_PX) : 1;

  function automatic logic [7:0] f_px(input logic [3:0] t);
    return 8'(t) * 8'(TILE_PX);
  endfunction

  function automatic logic [6:0] f_py(input logic [3:0] t);
    return 7'(t) * 7'(TILE_PX);
  endfunction

  logic [1:0]          r_state, w_state_nxt;
  logic [3:0]          r_tx1, r_ty1, r_tx2, r_ty2;
  logic [3:0]          w_tx1_nxt, w_ty1_nxt, w_tx2_nxt, w_ty2_nxt;
  logic [7:0]          r_px, w_px_nxt;
  logic [6:0]          r_py, w_py_nxt;
  logic                r_tmoving, w_tmoving_nxt;
  logic [2:0]          r_tdir, w_tdir_nxt;
  logic [1:0]          r_facing, w_facing_nxt;
  logic [c_STEP_W-1:0] r_step, w_step_nxt;
  logic                r_armed, w_armed_nxt;

  logic [3:0] w_dtx, w_dty;
  logic       w_dest_ok;
  logic       w_accept;
  logic       w_last_step;

  // Destination tile for the granted direction and whether it is on the map
  always_comb begin
    w_dtx     = r_tx1;
    w_dty     = r_ty1;
    w_dest_ok = 1'b0;
    case (grant[1:0])
      2'd0: begin w_dest_ok = (r_ty1 != 4'd0);           w_dty = r_ty1 - 4'd1; end
      2'd1: begin w_dest_ok = (r_ty1 < 4'(MAX_TILE));    w_dty = r_ty1 + 4'd1; end
      2'd2: begin w_dest_ok = (r_tx1 != 4'd0);           w_dtx = r_tx1 - 4'd1; end
      default: begin w_dest_ok = (r_tx1 < 4'(MAX_TILE)); w_dtx = r_tx1 + 4'd1; end
    endcase
  end

  assign w_accept    = (r_state == c_REQ) && grant[2] && w_dest_ok;
  assign w_last_step = (r_step == c_STEP_W'(TILE_PX - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= c_IDLE;
      r_tx1     <= 4'(INIT_TX);
      r_ty1     <= 4'(INIT_TY);
      r_tx2     <= 4'(INIT_TX);
      r_ty2     <= 4'(INIT_TY);
      r_px      <= f_px(4'(INIT_TX));
      r_py      <= f_py(4'(INIT_TY));
      r_tmoving <= 1'b0;
      r_tdir    <= 3'd0;
      r_facing  <= 2'd0;
      r_step    <= '0;
      r_armed   <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_tx1     <= w_tx1_nxt;
      r_ty1     <= w_ty1_nxt;
      r_tx2     <= w_tx2_nxt;
      r_ty2     <= w_ty2_nxt;
      r_px      <= w_px_nxt;
      r_py      <= w_py_nxt;
      r_tmoving <= w_tmoving_nxt;
      r_tdir    <= w_tdir_nxt;
      r_facing  <= w_facing_nxt;
      r_step    <= w_step_nxt;
      r_armed   <= w_armed_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:   if (key_dir[2] && r_armed) w_state_nxt = c_REQ;
      c_REQ: begin
        if (w_accept)         w_state_nxt = c_MOVE;
        else if (!key_dir[2]) w_state_nxt = c_IDLE;
      end
      c_MOVE:   if (tick && w_last_step) w_state_nxt = c_SETTLE;
      default: begin
`ifdef TANK_MOVER_AUTOREPEAT_EN
        w_state_nxt = key_dir[2] ? c_REQ : c_IDLE;
`else
        w_state_nxt = c_IDLE;
`endif
      end
    endcase
  end

  always_comb begin
    w_tx1_nxt     = r_tx1;
    w_ty1_nxt     = r_ty1;
    w_tx2_nxt     = r_tx2;
    w_ty2_nxt     = r_ty2;
    w_px_nxt      = r_px;
    w_py_nxt      = r_py;
    w_tmoving_nxt = r_tmoving;
    w_tdir_nxt    = r_tdir;
    w_facing_nxt  = r_facing;
    w_step_nxt    = r_step;
`ifdef TANK_MOVER_AUTOREPEAT_EN
    w_armed_nxt   = 1'b1;
`else
    // One tile per press: a held key must be released before the next request
    w_armed_nxt   = r_armed;
    if (!key_dir[2])   w_armed_nxt = 1'b1;
    else if (w_accept) w_armed_nxt = 1'b0;
`endif
    case (r_state)
      c_REQ: begin
        if (w_accept) begin
          w_facing_nxt  = grant[1:0];
          w_tx2_nxt     = w_dtx;
          w_ty2_nxt     = w_dty;
          w_tmoving_nxt = 1'b1;
          w_tdir_nxt    = {1'b0, grant[1:0]};
          w_step_nxt    = '0;
        end else begin
          w_tdir_nxt = {w_state_nxt == c_REQ, key_dir[1:0]};
        end
      end
      c_MOVE: begin
        if (tick) begin
          w_step_nxt = r_step + c_STEP_W'(1);
          case (r_facing)
            2'd0:    w_py_nxt = r_py - 7'd1;
            2'd1:    w_py_nxt = r_py + 7'd1;
            2'd2:    w_px_nxt = r_px - 8'd1;
            default: w_px_nxt = r_px + 8'd1;
          endcase
          // Arrival snaps to the exact tile origin
          if (w_last_step) begin
            w_tx1_nxt     = r_tx2;
            w_ty1_nxt     = r_ty2;
            w_px_nxt      = f_px(r_tx2);
            w_py_nxt      = f_py(r_ty2);
            w_tmoving_nxt = 1'b0;
            w_step_nxt    = '0;
          end
        end
      end
      default: w_tdir_nxt = {w_state_nxt == c_REQ, key_dir[1:0]};
    endcase
  end

  assign tdirection = r_tdir;
  assign tmoving    = r_tmoving;
  assign tx1        = r_tx1;
  assign ty1        = r_ty1;
  assign tx2        = r_tx2;
  assign ty2        = r_ty2;
  assign px         = r_px;
  assign py         = r_py;
  assign facing     = r_facing;

endmodule

`default_nettype wire

// File: tb/tb_tank_mover.sv
//------------------------------------------------------------------------------
// Module  : tb_tank_mover
// Brief   : Directed vector table plus hand-written move sequence for tank_mover.
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tank_mover;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] key_dir;
  logic       tick;
  logic [2:0] grant;
  logic [2:0] tdirection;
  logic       tmoving;
  logic [3:0] tx1, ty1, tx2, ty2;
  logic [7:0] px;
  logic [6:0] py;
  logic [1:0] facing;

  int tests = 0;
  int fails = 0;
  logic mon_en = 1'b0;

  tank_mover u_dut (
    .clk(clk), .reset(reset), .key_dir(key_dir), .tick(tick), .grant(grant),
    .tdirection(tdirection), .tmoving(tmoving),
    .tx1(tx1), .ty1(ty1), .tx2(tx2), .ty2(ty2),
    .px(px), .py(py), .facing(facing)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] key;
    logic       tk;
    logic [2:0] gnt;
    logic [2:0] tdir;
    logic       dchk;
    logic       tmov;
    logic [3:0] x1, y1, x2, y2;
    logic [7:0] px;
    logic [6:0] py;
    logic [1:0] fac;
  } vec_t;

  vec_t vq[$];

`ifdef TANK_MOVER_AUTOREPEAT_EN
  localparam logic [2:0] c_HELD_DIR = 3'b111;
`else
  localparam logic [2:0] c_HELD_DIR = 3'b011;
`endif

  function automatic void add(input logic r, input logic [2:0] k, input logic t,
                              input logic [2:0] g, input logic [2:0] td, input logic dc,
                              input logic tm, input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [3:0] d,
                              input logic [7:0] x, input logic [6:0] y, input logic [1:0] f);
    vec_t v;
    v.rst = r; v.key = k; v.tk = t; v.gnt = g; v.tdir = td; v.dchk = dc; v.tmov = tm;
    v.x1 = a; v.y1 = b; v.x2 = c; v.y2 = d; v.px = x; v.py = y; v.fac = f;
    vq.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input logic r, input logic [2:0] k, input logic t, input logic [2:0] g);
    reset = r; key_dir = k; tick = t; grant = g;
    @(posedge clk);
    #1;
  endtask

  // Request and movement must never be asserted together
  always @(negedge clk) begin
    if (mon_en) begin
      tests++;
      if (tdirection[2] && tmoving) begin
        fails++;
        $display("FAIL req_vs_moving: tdirection=%b tmoving=%b required not both high",
                 tdirection, tmoving);
      end
    end
  end

  initial begin
    reset = 1'b1; key_dir = 3'b000; tick = 1'b0; grant = 3'b000;

    //  rst key    tk gnt     tdir   dc mv x1 y1  x2 y2  px  py   f
    add(1, 3'b000, 0, 3'b000, 3'b000, 1, 0, 0, 12, 0, 12, 0, 108, 0); // reset state
    add(0, 3'b111, 0, 3'b000, 3'b111, 1, 0, 0, 12, 0, 12, 0, 108, 0); // IDLE -> REQ
    add(0, 3'b111, 0, 3'b110, 3'b111, 1, 0, 0, 12, 0, 12, 0, 108, 0); // left off-map ignored
    add(0, 3'b111, 1, 3'b111, 3'b000, 0, 1, 0, 12, 1, 12, 0, 108, 3); // grant right, tick ignored
    add(0, 3'b111, 1, 3'b100, 3'b000, 0, 1, 0, 12, 1, 12, 1, 108, 3); // grant during MOVE ignored
    add(0, 3'b111, 0, 3'b000, 3'b000, 0, 1, 0, 12, 1, 12, 1, 108, 3); // no tick, hold
    for (int i = 2; i <= 8; i++)
      add(0, 3'b111, 1, 3'b000, 3'b000, 0, 1, 0, 12, 1, 12, 8'(i), 108, 3);
    add(0, 3'b111, 1, 3'b000, 3'b000, 0, 0, 1, 12, 1, 12, 9, 108, 3); // 9th step: arrival
    add(0, 3'b111, 0, 3'b111, c_HELD_DIR, 1, 0, 1, 12, 1, 12, 9, 108, 3); // SETTLE, grant ignored
    add(0, 3'b111, 0, 3'b000, c_HELD_DIR, 1, 0, 1, 12, 1, 12, 9, 108, 3); // key still held
    add(0, 3'b011, 0, 3'b000, 3'b011, 1, 0, 1, 12, 1, 12, 9, 108, 3); // release
    add(0, 3'b111, 0, 3'b000, 3'b111, 1, 0, 1, 12, 1, 12, 9, 108, 3); // re-press -> REQ
    add(0, 3'b000, 0, 3'b100, 3'b000, 0, 1, 1, 12, 1, 11, 9, 108, 0); // grant wins over release
    for (int i = 1; i <= 4; i++)
      add(0, 3'b000, 1, 3'b000, 3'b000, 0, 1, 1, 12, 1, 11, 9, 7'(108 - i), 0);
    add(1, 3'b000, 1, 3'b000, 3'b000, 1, 0, 0, 12, 0, 12, 0, 108, 0); // reset mid-move
    add(0, 3'b000, 0, 3'b000, 3'b000, 1, 0, 0, 12, 0, 12, 0, 108, 0); // IDLE after reset

    foreach (vq[n]) begin
      cyc(vq[n].rst, vq[n].key, vq[n].tk, vq[n].gnt);
      mon_en = 1'b1;
      chk($sformatf("v%0d_treq", n), 32'(tdirection[2]), 32'(vq[n].tdir[2]));
      if (vq[n].dchk) chk($sformatf("v%0d_tdir", n), 32'(tdirection), 32'(vq[n].tdir));
      chk($sformatf("v%0d_tmoving", n), 32'(tmoving), 32'(vq[n].tmov));
      chk($sformatf("v%0d_tx1", n), 32'(tx1), 32'(vq[n].x1));
      chk($sformatf("v%0d_ty1", n), 32'(ty1), 32'(vq[n].y1));
      chk($sformatf("v%0d_tx2", n), 32'(tx2), 32'(vq[n].x2));
      chk($sformatf("v%0d_ty2", n), 32'(ty2), 32'(vq[n].y2));
      chk($sformatf("v%0d_px", n), 32'(px), 32'(vq[n].px));
      chk($sformatf("v%0d_py", n), 32'(py), 32'(vq[n].py));
      chk($sformatf("v%0d_facing", n), 32'(facing), 32'(vq[n].fac));
    end

    // Full upward move after an aborted one: step counter must restart at zero
    cyc(0, 3'b100, 0, 3'b000);
    chk("up_req_tdir", 32'(tdirection), 32'(3'b100));
    cyc(0, 3'b100, 0, 3'b101);
    chk("down_offmap_tdir", 32'(tdirection), 32'(3'b100));
    chk("down_offmap_ty2", 32'(ty2), 32'd12);
    chk("down_offmap_tmoving", 32'(tmoving), 32'd0);
    cyc(0, 3'b000, 0, 3'b100);
    chk("up_grant_tmoving", 32'(tmoving), 32'd1);
    chk("up_grant_ty2", 32'(ty2), 32'd11);
    chk("up_grant_facing", 32'(facing), 32'd0);
    for (int i = 1; i <= 9; i++) begin
      cyc(0, 3'b000, 1, 3'b000);
      chk($sformatf("up_step%0d_py", i), 32'(py), 32'(108 - i));
      chk($sformatf("up_step%0d_tmoving", i), 32'(tmoving), (i < 9) ? 32'd1 : 32'd0);
      cyc(0, 3'b000, 0, 3'b000);
      chk($sformatf("up_gap%0d_py", i), 32'(py), 32'(108 - i));
    end
    chk("up_done_ty1", 32'(ty1), 32'd11);
    chk("up_done_ty2", 32'(ty2), 32'd11);
    chk("up_done_treq", 32'(tdirection[2]), 32'd0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
